// File: rtl/tcdm_bank_arbiter_if.sv
// Channel and bank signal bundle for tcdm_bank_arbiter.
// The slave modport is the arbiter's view; master is the initiator/bank-model view.
interface tcdm_bank_arbiter_if #(
    parameter int N_CH = 8,
    parameter int DW   = 32,
    parameter int AW   = 13
);
    localparam int BW = DW / 8;

    logic [N_CH-1:0]          ch_req_i;
    logic [N_CH-1:0]          ch_gnt_o;
    logic [N_CH-1:0][AW-1:0]  ch_add_i;
    logic [N_CH-1:0]          ch_wen_i;
    logic [N_CH-1:0][BW-1:0]  ch_be_i;
    logic [N_CH-1:0][DW-1:0]  ch_wdata_i;
    logic [N_CH-1:0]          ch_r_valid_o;
    logic [DW-1:0]            ch_r_rdata_o;

    logic                     bank_req_o;
    logic [AW-1:0]            bank_add_o;
    logic                     bank_wen_o;
    logic [BW-1:0]            bank_be_o;
    logic [DW-1:0]            bank_wdata_o;
    logic [DW-1:0]            bank_rdata_i;

    modport slave (
        input  ch_req_i, ch_add_i, ch_wen_i, ch_be_i, ch_wdata_i, bank_rdata_i,
        output ch_gnt_o, ch_r_valid_o, ch_r_rdata_o,
        output bank_req_o, bank_add_o, bank_wen_o, bank_be_o, bank_wdata_o
    );

    modport master (
        output ch_req_i, ch_add_i, ch_wen_i, ch_be_i, ch_wdata_i, bank_rdata_i,
        input  ch_gnt_o, ch_r_valid_o, ch_r_rdata_o,
        input  bank_req_o, bank_add_o, bank_wen_o, bank_be_o, bank_wdata_o
    );
endinterface

// File: rtl/tcdm_bank_arbiter.sv
// N-to-1 TCDM bank arbiter: round-robin / fixed / two-group policies, 1-cycle response routing.
// Optional low-group starvation guard enabled by defining TCDM_ARB_STARVE_GUARD_EN.
module tcdm_bank_arbiter #(
    parameter int N_CH        = 8,
    parameter int DW          = 32,
    parameter int AW          = 13,
    parameter int N_HI        = 4,
    parameter int STALL_LIMIT = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         arb_policy_i,
    tcdm_bank_arbiter_if.slave bus
);
    localparam int BW = DW / 8;
    localparam int PW = $clog2(N_CH);
    localparam logic [N_CH-1:0] HI_MASK = {{(N_CH-N_HI){1'b0}}, {N_HI{1'b1}}};

    if (N_CH < 2 || N_HI < 1 || N_HI >= N_CH || STALL_LIMIT < 1 || (DW % 8) != 0) begin : g_bad_cfg
        $error("tcdm_bank_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {
        POL_RR     = 2'b00,
        POL_FIXED  = 2'b01,
        POL_GROUP  = 2'b10,
        POL_RR_ALT = 2'b11
    } policy_e;

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] idx;
    } pick_t;

    // First set bit at or after ptr, wrapping at N_CH-1.
    function automatic pick_t rr_pick(input logic [N_CH-1:0] mask, input logic [PW-1:0] ptr);
        pick_t         pick;
        logic [PW-1:0] pos;
        pick = '0;
        pos  = ptr;
        for (int k = 0; k < N_CH; k++) begin
            if (!pick.valid && mask[pos]) begin
                pick.valid = 1'b1;
                pick.idx   = pos;
            end
            pos = (pos == PW'(N_CH-1)) ? '0 : pos + 1'b1;
        end
        return pick;
    endfunction

    function automatic pick_t low_pick(input logic [N_CH-1:0] mask);
        return rr_pick(mask, '0);
    endfunction

    policy_e         policy;
    pick_t           win;
    logic [N_CH-1:0] hi_req, lo_req, gnt;
    logic            force_lo;
    logic [PW-1:0]   ptr_d, ptr_q;
    logic [N_CH-1:0] resp_d, resp_q;
    logic [AW-1:0]   bank_add;
    logic            bank_wen;
    logic [BW-1:0]   bank_be;
    logic [DW-1:0]   bank_wdata;

`ifdef TCDM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [SW-1:0] stall_d, stall_q;
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        policy     = policy_e'(arb_policy_i);
        hi_req     = bus.ch_req_i & HI_MASK;
        lo_req     = bus.ch_req_i & ~HI_MASK;
        force_lo   = 1'b0;
        win        = '0;
        gnt        = '0;
        bank_add   = '0;
        bank_wen   = 1'b0;
        bank_be    = '0;
        bank_wdata = '0;

`ifdef TCDM_ARB_STARVE_GUARD_EN
        force_lo = (policy == POL_GROUP) && (|lo_req) && (stall_q == SW'(STALL_LIMIT));
`endif

        case (policy)
            POL_FIXED: win = low_pick(bus.ch_req_i);
            POL_GROUP: win = (force_lo || hi_req == '0) ? rr_pick(lo_req, ptr_q)
                                                        : rr_pick(hi_req, ptr_q);
            default:   win = rr_pick(bus.ch_req_i, ptr_q);
        endcase

        if (win.valid) begin
            gnt[win.idx] = 1'b1;
            bank_add     = bus.ch_add_i[win.idx];
            bank_wen     = bus.ch_wen_i[win.idx];
            bank_be      = bus.ch_be_i[win.idx];
            bank_wdata   = bus.ch_wdata_i[win.idx];
        end

        ptr_d = ptr_q;
        if (win.valid && policy != POL_FIXED) begin
            ptr_d = (win.idx == PW'(N_CH-1)) ? '0 : win.idx + 1'b1;
        end
        resp_d = gnt;

`ifdef TCDM_ARB_STARVE_GUARD_EN
        // Count only cycles where the low group waits behind a high-group grant.
        if (policy != POL_GROUP || lo_req == '0 || (win.valid && !HI_MASK[win.idx])) begin
            stall_d = '0;
        end else begin
            stall_d = stall_q + 1'b1;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        // NOTE: synchronous reset clears only control state; datapath is combinational and needs none.
        if (!rst_ni) begin
            ptr_q  <= '0;
            resp_q <= '0;
`ifdef TCDM_ARB_STARVE_GUARD_EN
            stall_q <= '0;
`endif
        end else begin
            ptr_q  <= ptr_d;
            resp_q <= resp_d;
`ifdef TCDM_ARB_STARVE_GUARD_EN
            stall_q <= stall_d;
`endif
        end
    end

    assign bus.ch_gnt_o     = gnt;
    assign bus.ch_r_valid_o = resp_q;
    assign bus.ch_r_rdata_o = bus.bank_rdata_i;
    assign bus.bank_req_o   = |bus.ch_req_i;
    assign bus.bank_add_o   = bank_add;
    assign bus.bank_wen_o   = bank_wen;
    assign bus.bank_be_o    = bank_be;
    assign bus.bank_wdata_o = bank_wdata;
endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Self-checking bench for tcdm_bank_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a distance-based arbitration model.
module tb_tcdm_bank_arbiter;
    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int AW  = 13;
    localparam int NHI = 4;
    localparam int SL  = 4;
    localparam int BW  = DW / 8;
`ifdef TCDM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] policy;

    tcdm_bank_arbiter_if #(.N_CH(N), .DW(DW), .AW(AW)) bus ();

    tcdm_bank_arbiter #(
        .N_CH(N), .DW(DW), .AW(AW), .N_HI(NHI), .STALL_LIMIT(SL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .arb_policy_i (policy),
        .bus          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: pointer, stall count, response vector expected this cycle.
    int           m_ptr   = 0;
    int           m_stall = 0;
    logic [N-1:0] m_resp  = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Winner = requester with the smallest forward distance from the pointer.
    function automatic int model_winner(input logic [N-1:0] req, input logic [1:0] pol,
                                        input int ptr, input int stall);
        logic [N-1:0] hi, lo, cand;
        int best, bestd, d;
        hi = '0;
        lo = '0;
        for (int c = 0; c < N; c++) begin
            if (c < NHI) hi[c] = req[c];
            else         lo[c] = req[c];
        end
        best  = -1;
        bestd = N + 1;
        if (pol == 2'b01) begin
            for (int c = N - 1; c >= 0; c--) if (req[c]) best = c;
            return best;
        end
        cand = req;
        if (pol == 2'b10) begin
            if (GUARD && lo != '0 && stall == SL) cand = lo;
            else if (hi != '0)                    cand = hi;
            else                                  cand = lo;
        end
        for (int c = 0; c < N; c++) begin
            d = (c - ptr + N) % N;
            if (cand[c] && d < bestd) begin
                best  = c;
                bestd = d;
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin : compare
        int           w;
        logic [N-1:0] eg;
        logic [AW-1:0] ea;
        logic          ew;
        logic [BW-1:0] eb;
        logic [DW-1:0] ed;
        logic          lo_any;
        if (chk_en) begin
            w  = model_winner(bus.ch_req_i, policy, m_ptr, m_stall);
            eg = '0;
            ea = '0; ew = 1'b0; eb = '0; ed = '0;
            if (w >= 0) begin
                eg[w] = 1'b1;
                ea = bus.ch_add_i[w];
                ew = bus.ch_wen_i[w];
                eb = bus.ch_be_i[w];
                ed = bus.ch_wdata_i[w];
            end
            check("gnt",        64'(bus.ch_gnt_o),     64'(eg));
            check("bank_req",   64'(bus.bank_req_o),   64'(bus.ch_req_i != '0));
            check("bank_add",   64'(bus.bank_add_o),   64'(ea));
            check("bank_wen",   64'(bus.bank_wen_o),   64'(ew));
            check("bank_be",    64'(bus.bank_be_o),    64'(eb));
            check("bank_wdata", 64'(bus.bank_wdata_o), 64'(ed));
            check("r_valid",    64'(bus.ch_r_valid_o), 64'(m_resp));
            check("r_rdata",    64'(bus.ch_r_rdata_o), 64'(bus.bank_rdata_i));

            lo_any = (bus.ch_req_i >> NHI) != '0;
            if (!rst_n) begin
                m_ptr   = 0;
                m_stall = 0;
                m_resp  = '0;
            end else begin
                m_resp = eg;
                if (w >= 0 && policy != 2'b01) m_ptr = (w + 1) % N;
                if (GUARD) begin
                    if (policy != 2'b10 || !lo_any || w >= NHI) m_stall = 0;
                    else                                       m_stall = m_stall + 1;
                end
            end
        end
    end

    task automatic rand_payload(input int c);
        bus.ch_add_i[c]   = AW'($urandom);
        bus.ch_wen_i[c]   = 1'($urandom_range(0, 1));
        bus.ch_be_i[c]    = BW'($urandom);
        bus.ch_wdata_i[c] = $urandom;
    endtask

    task automatic set_reqs(input logic [N-1:0] m);
        for (int c = 0; c < N; c++) rand_payload(c);
        bus.ch_req_i = m;
    endtask

    // One cycle: check the grant against a hand-computed value, then advance.
    task automatic cyc(input string name, input logic [N-1:0] exp_gnt);
        @(negedge clk);
        check(name, 64'(bus.ch_gnt_o), 64'(exp_gnt));
        @(posedge clk);
        #1;
        bus.bank_rdata_i = $urandom;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [N-1:0] g;
        logic [N-1:0] exp_g;

        rst_n  = 1'b0;
        policy = 2'b00;
        set_reqs('0);
        bus.bank_rdata_i = $urandom;

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_r_valid",  64'(bus.ch_r_valid_o), 64'(0));
        check("idle_bank_req", 64'(bus.bank_req_o),   64'(0));
        check("idle_bank_add", 64'(bus.bank_add_o),   64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin sweep from reset.
        set_reqs('1);
        for (int i = 0; i < 9; i++) cyc("rr_order", N'(1) << (i % N));

        // Wrap-around: get pointer to 7, then channels 2 and 7.
        set_reqs(8'h40); cyc("wrap_pre",  8'h40);
        set_reqs(8'h84); cyc("wrap_7",    8'h80);
        set_reqs(8'h04); cyc("wrap_2",    8'h04);
        set_reqs(8'hFF); cyc("wrap_ptr3", 8'h08);

        // Fixed priority holds pointer (4); switching back to RR picks 5.
        policy = 2'b01;
        set_reqs(8'h28);
        repeat (5) cyc("fixed_3", 8'h08);
        policy = 2'b00;
        cyc("ptr_kept", 8'h20);

        // Group priority, channel 0 vs channel 6.
        policy = 2'b10;
        set_reqs(8'h41);
        for (int i = 0; i < 10; i++) begin
            exp_g = (GUARD && (i % 5) == 4) ? 8'h40 : 8'h01;
            cyc("group", exp_g);
        end

        // Reset with a response pending.
        policy = 2'b00;
        set_reqs(8'h04);
        rst_n = 1'b0;
        @(negedge clk);
        check("pre_rst_gnt2", 64'(bus.ch_gnt_o), 64'(8'h04));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_reqs(8'hFF);
        @(negedge clk);
        check("rst_drop_valid", 64'(bus.ch_r_valid_o), 64'(0));
        check("post_rst_gnt0",  64'(bus.ch_gnt_o),     64'(8'h01));
        @(posedge clk);
        #1;

        // Idle then a single write from channel 1.
        set_reqs('0);
        @(negedge clk);
        check("idle_req",   64'(bus.bank_req_o),   64'(0));
        check("idle_wen",   64'(bus.bank_wen_o),   64'(0));
        check("idle_be",    64'(bus.bank_be_o),    64'(0));
        check("idle_wdata", 64'(bus.bank_wdata_o), 64'(0));
        @(posedge clk);
        #1;
        bus.ch_req_i      = 8'h02;
        bus.ch_add_i[1]   = 13'h123;
        bus.ch_wen_i[1]   = 1'b0;
        bus.ch_be_i[1]    = 4'b0101;
        bus.ch_wdata_i[1] = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_gnt",   64'(bus.ch_gnt_o),     64'(8'h02));
        check("wr_req",   64'(bus.bank_req_o),   64'(1));
        check("wr_add",   64'(bus.bank_add_o),   64'(13'h123));
        check("wr_wen",   64'(bus.bank_wen_o),   64'(0));
        check("wr_be",    64'(bus.bank_be_o),    64'(4'b0101));
        check("wr_wdata", 64'(bus.bank_wdata_o), 64'(32'hDEADBEEF));
        @(posedge clk);
        #1;
        set_reqs('0);
        @(negedge clk);
        check("wr_r_valid", 64'(bus.ch_r_valid_o), 64'(8'h02));
        @(posedge clk);
        #1;

        // Randomized traffic: initiators hold request and payload until granted.
        for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
            @(negedge clk);
            g = bus.ch_gnt_o;
            @(posedge clk);
            #1;
            bus.bank_rdata_i = $urandom;
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 31) == 0) policy = 2'($urandom_range(0, 3));
            for (int c = 0; c < N; c++) begin
                if (g[c] || !bus.ch_req_i[c]) begin
                    rand_payload(c);
                    bus.ch_req_i[c] = (c < NHI) ? ($urandom_range(0, 3) != 0)
                                                : ($urandom_range(0, 1) != 0);
                end
            end
        end

        rst_n = 1'b1;
        set_reqs('0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
